// File: rtl/sqr_cbrt_sum.sv
// rtl/sqr_cbrt_sum.sv - y = a^2 + cbrt(b): shift-add squarer plus external cube-root handshake
module sqr_cbrt_sum #(
    parameter int A_W         = 8,
    parameter int CBRT_SETTLE = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [A_W-1:0]     a_bi,
    input  logic [A_W-1:0]     b_bi,
    output logic               cbrt_start_o,
    output logic [A_W-1:0]     cbrt_a_bo,
    input  logic               cbrt_busy_i,
    input  logic [2:0]         cbrt_y_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [2*A_W-1:0]   y_bo
);

    localparam int Y_W = 2 * A_W;
    localparam int CW  = $clog2(A_W) + 1;
    localparam int SW  = $clog2(CBRT_SETTLE + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SQR,
        WAIT_CBRT,
        ADD
    } state_t;

    state_t          state;
    logic [A_W-1:0]  a_q;
    logic [A_W-1:0]  mplier;
    logic [Y_W-1:0]  acc;
    logic [Y_W-1:0]  mcand;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   settle;
    logic [2:0]      root;

    // Control FSM, squarer datapath, root capture and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            a_q          <= '0;
            mplier       <= '0;
            acc          <= '0;
            mcand        <= '0;
            cnt          <= '0;
            settle       <= '0;
            root         <= '0;
            cbrt_start_o <= 1'b0;
            cbrt_a_bo    <= '0;
            busy_o       <= 1'b0;
            valid_o      <= 1'b0;
            y_bo         <= '0;
        end else begin
            // Both strobes are single-cycle; only the states below raise them
            cbrt_start_o <= 1'b0;
            valid_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q          <= a_bi;
                        cbrt_a_bo    <= b_bi;
                        cbrt_start_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // The cube-root unit sees its start pulse during this cycle
                    acc    <= '0;
                    mcand  <= {{A_W{1'b0}}, a_q};
                    mplier <= a_q;
                    cnt    <= '0;
                    state  <= SQR;
                end
                SQR: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(A_W - 1)) begin
                        settle <= '0;
                        state  <= WAIT_CBRT;
                    end
                end
                WAIT_CBRT: begin
                    // Root output lags busy by a register, so require consecutive idle cycles
                    if (cbrt_busy_i) begin
                        settle <= '0;
                    end else if (settle == SW'(CBRT_SETTLE - 1)) begin
                        root   <= cbrt_y_i;
                        settle <= settle + 1'b1;
                        state  <= ADD;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                ADD: begin
                    y_bo    <= acc + {{(Y_W-3){1'b0}}, root};
                    valid_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqr_cbrt_sum.sv
// tb/tb_sqr_cbrt_sum.sv - scoreboard bench for sqr_cbrt_sum with a cube-root unit model
module tb_sqr_cbrt_sum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a_bi = '0;
    logic [7:0]  b_bi = '0;
    logic        cbrt_start;
    logic [7:0]  cbrt_a;
    logic        cbrt_busy;
    logic [2:0]  cbrt_y = '0;
    logic        busy;
    logic        valid;
    logic [15:0] y;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int exp_b = 0;
    int ops = 0;
    int start_pulses = 0;
    bit prev_start = 1'b0;

    typedef struct {
        int y;
        int lat;
    } exp_t;
    exp_t exp_q[$];

    // Cube-root unit model
    int   model_l = 0;
    int   model_cnt = 0;
    bit   model_pend = 1'b0;
    logic model_busy;
    logic glitch_busy = 1'b0;
    bit   glitch_mode = 1'b0;

    assign model_busy = (model_cnt != 0);
    assign cbrt_busy  = model_busy | glitch_busy;

    sqr_cbrt_sum #(.A_W(8), .CBRT_SETTLE(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .a_bi         (a_bi),
        .b_bi         (b_bi),
        .cbrt_start_o (cbrt_start),
        .cbrt_a_bo    (cbrt_a),
        .cbrt_busy_i  (cbrt_busy),
        .cbrt_y_i     (cbrt_y),
        .busy_o       (busy),
        .valid_o      (valid),
        .y_bo         (y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int icbrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    always @(posedge clk) begin
        if (cbrt_start) begin
            model_cnt  <= model_l;
            model_pend <= 1'b1;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
        end else if (model_pend) begin
            cbrt_y     <= 3'(icbrt(int'(cbrt_a)));
            model_pend <= 1'b0;
        end
    end

    // Scripted busy glitch: low one cycle in WAIT_CBRT, high again, then low
    always @(negedge clk) begin
        int step;
        step = cyc - start_cyc;
        glitch_busy <= glitch_mode && (step < 9 || (step >= 10 && step < 13));
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on valid and polices the start pulse
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("y_bo", int'(y), e.y);
                if (e.lat >= 0) check("latency", cyc - start_cyc, e.lat);
            end
        end
        if (cbrt_start) begin
            start_pulses++;
            check("cbrt_a_bo", int'(cbrt_a), exp_b);
            check("cbrt_start_width", int'(prev_start), 0);
            check("start_and_valid", int'(valid), 0);
        end
        prev_start = cbrt_start;
    end

    task automatic run_op(input int a, input int b, input int l, input int ey,
                          input int lat, input bit inject);
        int bad = 0;
        bit seen = 1'b0;
        @(negedge clk);
        model_l   = l;
        a_bi      = 8'(a);
        b_bi      = 8'(b);
        start     = 1'b1;
        start_cyc = cyc + 1;
        exp_b     = b;
        exp_q.push_back('{y: ey, lat: lat});
        ops++;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                a_bi  = 8'($urandom);
                b_bi  = 8'($urandom);
            end
            if (inject && i == 3) begin
                start = 1'b1;
                a_bi  = 8'd9;
                b_bi  = 8'd8;
            end
            if (inject && i == 4) start = 1'b0;
            if (valid) seen = 1'b1;
            else if (!busy) bad++;
        end
        check("valid_seen", int'(seen), 1);
        check("busy_during_op", bad, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_y", int'(y), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cbrt_start", int'(cbrt_start), 0);
        check("rst_cbrt_a", int'(cbrt_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(3, 27, 0, 12, 12, 1'b0);
        run_op(255, 255, 30, 65031, 34, 1'b0);
        run_op(0, 0, 0, 0, 12, 1'b0);
        run_op(1, 1, 0, 2, 12, 1'b0);
        repeat (5) @(negedge clk);
        check("y_hold", int'(y), 2);
        run_op(5, 27, 0, 28, 12, 1'b1);
        repeat (20) @(negedge clk);
        check("y_hold_after_inject", int'(y), 28);

        // Abort mid-SQR with an asynchronous reset between edges
        @(negedge clk);
        a_bi = 8'd7; b_bi = 8'd1; start = 1'b1; start_cyc = cyc + 1; exp_b = 1; ops++;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_y", int'(y), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_cbrt_start", int'(cbrt_start), 0);
        check("abort_cbrt_a", int'(cbrt_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_op(10, 64, 0, 104, 12, 1'b0);

        glitch_mode = 1'b1;
        run_op(4, 125, 0, 21, 16, 1'b0);
        glitch_mode = 1'b0;

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("start_pulses", start_pulses, ops);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqr_cbrt_sum.md
Name: sqr_cbrt_sum

Overview:
- Top-level compute stage for y = a^2 + cbrt(b), placed directly upstream of the cube-root unit and consuming its result.
- Captures operands a and b, launches the cube-root unit on b with a one-cycle start pulse, and squares a in parallel with an iterative shift-add.
- Collects the 3-bit root once the cube-root unit has settled, then adds it to a^2.
- Presents a registered 16-bit result with a one-cycle valid strobe.

Parameters:
- A_W, 8: operand width for a_bi and b_bi; the square is 2*A_W bits.
- CBRT_SETTLE, 2: number of consecutive cycles cbrt_busy_i must be low before cbrt_y_i is sampled.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request strobe; sampled only in IDLE.
- a_bi  in  A_W  operand to square; captured with start_i.
- b_bi  in  A_W  operand for the cube root; captured with start_i.
- cbrt_start_o  out  1  start pulse to the cube-root unit (drives its active-high start/reset input).
- cbrt_a_bo  out  A_W  operand to the cube-root unit.
- cbrt_busy_i  in  1  busy from the cube-root unit.
- cbrt_y_i  in  3  result from the cube-root unit.
- busy_o  out  1  high whenever state != IDLE.
- valid_o  out  1  one-cycle pulse; y_bo is new.
- y_bo  out  2*A_W  registered a^2 + cbrt(b).

Behaviour:
- Async reset (rst_ni=0) forces, immediately and independent of clk_i:
  - state=IDLE; y_bo=0, valid_o=0, busy_o=0, cbrt_start_o=0, cbrt_a_bo=0;
  - square accumulator, bit counter, settle counter and captured root all 0.
- Reset mid-operation abandons the operation with no valid_o. The cube-root unit may keep running; its result is ignored because the next operation relaunches it.
- States: IDLE, LAUNCH, SQR, WAIT_CBRT, ADD.
- IDLE:
  - start_i=1 latches a and b, sets cbrt_a_bo=b_bi, and moves to LAUNCH.
  - start_i=0 stays in IDLE. y_bo holds its last value.
- LAUNCH (exactly 1 cycle):
  - cbrt_start_o=1 for this cycle only; cbrt_a_bo stable.
  - Initialise the squarer: acc=0, mcand=zero-extended a, mplier=a, cnt=0. Go to SQR.
- SQR (exactly A_W cycles):
  - Each cycle: if mplier[0]=1 then acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
  - After A_W iterations go to WAIT_CBRT with the settle counter cleared.
  - acc is 2*A_W bits and cannot overflow, since 255^2 = 65025.
- WAIT_CBRT:
  - Settle counter increments while cbrt_busy_i=0 and clears whenever cbrt_busy_i=1.
  - When the counter reaches CBRT_SETTLE, latch cbrt_y_i and go to ADD.
  - The two-cycle settle covers the root output being registered one cycle after the cube-root unit's busy falls.
  - No timeout.
- ADD (1 cycle):
  - y_bo <= acc + zero-extended root; valid_o=1 on the following cycle; return to IDLE.
  - Sum is at most 65025+7 = 65032, so no overflow at A_W=8.
- Latency: start_i sampled at edge N gives valid_o high in cycle N + 1 + A_W + CBRT_SETTLE + 1 if the cube-root unit is already idle during SQR. Default minimum is 12 cycles; otherwise the latency stretches by the extra busy time.
- start_i while busy_o=1 is ignored; it is neither queued nor allowed to disturb the operands.
- start_i held high continuously: a new operation begins on the first IDLE cycle after ADD, so back-to-back operations are 1 idle cycle apart.
- valid_o and cbrt_start_o are single-cycle pulses and never high simultaneously in the same operation.
- Inputs a_bi and b_bi may change freely after capture.

Test Plan:
- Bench uses a cube-root model with a programmable busy length L and result floor(cbrt(b)).
- a=3, b=27, L=0 -> valid_o exactly 12 cycles after start, y_bo=12, cbrt_start_o high for exactly 1 cycle with cbrt_a_bo=27.
- a=255, b=255, L=30 -> valid_o after the model's busy falls plus 2 cycles, y_bo=65031; busy_o high throughout.
- a=0, b=0 -> y_bo=0; then a=1, b=1 -> y_bo=2; y_bo holds between operations.
- start_i pulsed again during SQR with a=9, b=8 -> ignored; first result unchanged, no second valid_o until the next start in IDLE.
- rst_ni pulled low asynchronously mid-SQR (between clock edges) -> all outputs 0 at once, no valid_o; after release, a=10, b=64 -> y_bo=104.
- cbrt_busy_i glitching low for 1 cycle then high again in WAIT_CBRT -> settle counter restarts; result is sampled only after 2 consecutive low cycles.
